// File: rtl/console_pkg.sv
// console_pkg: shared sizes, control codes, state encoding and cell packing for text_console_ctrl (CONSOLE_RESET_CLEAR_EN adds INIT)
package console_pkg;
  localparam int DEF_COLS = 160;
  localparam int DEF_ROWS = 45;
  localparam logic [31:0] DEF_CLEAR = 32'hFFF00020;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_BS = 8'h08;
  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    BUMP
`ifdef CONSOLE_RESET_CLEAR_EN
    , INIT
`endif
  } state_t;
  function automatic logic [31:0] pack_cell(input logic [11:0] fg, input logic [11:0] bg, input logic [7:0] ch);
    return {fg, bg, ch};
  endfunction
endpackage

// File: rtl/fb_clear_walker.sv
// fb_clear_walker: walks cells row-major over a row range, one per cycle, pulsing done after the last
module fb_clear_walker #(
  parameter int COLS = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [5:0] y_lo,
  input  logic [5:0] y_hi,
  output logic       emit,
  output logic [7:0] x,
  output logic [5:0] y,
  output logic       done
);
  logic       active;
  logic [5:0] yh;
  logic       eol;
  logic       last;
  assign eol  = x == 8'(COLS - 1);
  assign last = eol && y == yh;
  assign emit = active;
  // counters advance while active; done registers one cycle after the final cell
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      done   <= 1'b0;
      x      <= '0;
      y      <= '0;
      yh     <= '0;
    end else begin
      done <= active && last;
      if (start) begin
        active <= 1'b1;
        x      <= x0;
        y      <= y_lo;
        yh     <= y_hi;
      end else if (active) begin
        x      <= eol ? 8'd0 : x + 8'd1;
        y      <= eol && !last ? y + 6'd1 : y;
        active <= !last;
      end
    end
  end
endmodule

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: byte-stream terminal sequencer for the text framebuffer write port (CONSOLE_RESET_CLEAR_EN clears the screen after reset)
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int          COLS        = DEF_COLS,
  parameter int          ROWS        = DEF_ROWS,
  parameter logic [31:0] CLEAR_VALUE = DEF_CLEAR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  char_data,
  input  logic [11:0] char_fg,
  input  logic [11:0] char_bg,
  output logic [7:0]  write_posx,
  output logic [5:0]  write_posy,
  output logic [31:0] write_value,
  output logic        write_enable,
  output logic [5:0]  v_offset,
  output logic        busy
);
  state_t     state, state_n;
  logic [7:0] col;
  logic [5:0] row;
  logic [6:0] sum;
  logic [5:0] phys;
  logic       accept, is_lf, is_cr, is_bs, glyph, eol, bottom, nl, scroll;
  logic       w_start, w_emit, w_done;
  logic [7:0] w_x0, w_x;
  logic [5:0] w_ylo, w_yhi, w_y;
  assign char_ready = state == IDLE;
  assign busy       = state != IDLE;
  assign accept     = char_valid && char_ready;
  assign is_lf      = char_data == CC_LF;
  assign is_cr      = char_data == CC_CR;
  assign is_bs      = char_data == CC_BS;
  assign glyph      = accept && !is_lf && !is_cr && !is_bs;
  assign eol        = col == 8'(COLS - 1);
  assign bottom     = row == 6'(ROWS - 1);
  assign nl         = (accept && is_lf) || (glyph && eol);
  assign scroll     = nl && bottom;
  assign sum        = {1'b0, row} + {1'b0, v_offset};
  assign phys       = 6'(sum >= 7'(ROWS) ? sum - 7'(ROWS) : sum);
  fb_clear_walker #(.COLS(COLS)) u_walker (
    .clk  (clk),
    .rst  (rst),
    .start(w_start),
    .x0   (w_x0),
    .y_lo (w_ylo),
    .y_hi (w_yhi),
    .emit (w_emit),
    .x    (w_x),
    .y    (w_y),
    .done (w_done)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef CONSOLE_RESET_CLEAR_EN
      state <= INIT;
`else
      state <= IDLE;
`endif
    end else begin
      state <= state_n;
    end
  end
  // next state and walker launch; an LF scroll writes cell 0 itself so the walker starts at column 1
  always_comb begin
    state_n = state;
    w_start = 1'b0;
    w_x0    = glyph ? 8'd0 : 8'd1;
    w_ylo   = v_offset;
    w_yhi   = v_offset;
    case (state)
      IDLE: begin
        w_start = scroll;
        state_n = scroll ? CLEAR : IDLE;
      end
      CLEAR: state_n = w_done ? BUMP : CLEAR;
      BUMP: state_n = IDLE;
`ifdef CONSOLE_RESET_CLEAR_EN
      INIT: begin
        w_start = !w_done && !w_emit;
        w_x0    = 8'd0;
        w_ylo   = 6'd0;
        w_yhi   = 6'(ROWS - 1);
        state_n = w_done ? IDLE : INIT;
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  // registered write port, cursor and scroll offset
  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      v_offset     <= '0;
      write_enable <= 1'b0;
      write_posx   <= '0;
      write_posy   <= '0;
      write_value  <= '0;
    end else begin
      write_enable <= glyph || scroll || w_emit;
      if (glyph) begin
        write_posx  <= col;
        write_posy  <= phys;
        write_value <= pack_cell(char_fg, char_bg, char_data);
      end else if (scroll) begin
        write_posx  <= 8'd0;
        write_posy  <= v_offset;
        write_value <= CLEAR_VALUE;
      end else if (w_emit) begin
        write_posx  <= w_x;
        write_posy  <= w_y;
        write_value <= CLEAR_VALUE;
      end
      if ((accept && is_cr) || (glyph && eol))
        col <= 8'd0;
      else if (glyph)
        col <= col + 8'd1;
      else if (accept && is_bs && col != 8'd0)
        col <= col - 8'd1;
      if (nl && !bottom)
        row <= row + 6'd1;
      if (state == BUMP)
        v_offset <= v_offset == 6'(ROWS - 1) ? 6'd0 : v_offset + 6'd1;
    end
  end
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: scoreboard bench for text_console_ctrl; honours CONSOLE_RESET_CLEAR_EN
module tb_text_console_ctrl;
  localparam logic [31:0] CLR = 32'hFFF00020;
`ifdef CONSOLE_RESET_CLEAR_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [7:0]  char_data = 8'd0;
  logic [11:0] char_fg = 12'd0;
  logic [11:0] char_bg = 12'd0;
  logic [7:0]  write_posx;
  logic [5:0]  write_posy;
  logic [31:0] write_value;
  logic        write_enable;
  logic [5:0]  v_offset;
  logic        busy;
  int checks = 0;
  int failures = 0;
  logic [45:0] exp_q[$];
  logic [45:0] mon_e;
  int m_col = 0, m_row = 0, m_voff = 0;
  int stalls = 0;

  always #5 clk = ~clk;

  text_console_ctrl dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_ready(char_ready),
    .char_data(char_data), .char_fg(char_fg), .char_bg(char_bg),
    .write_posx(write_posx), .write_posy(write_posy), .write_value(write_value),
    .write_enable(write_enable), .v_offset(v_offset), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && write_enable) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected: got x=%0d y=%0d v=%h expected none", write_posx, write_posy, write_value);
      end else begin
        mon_e = exp_q.pop_front();
        if ({write_posx, write_posy, write_value} !== mon_e) begin
          failures++;
          $display("FAIL write: got x=%0d y=%0d v=%h expected x=%0d y=%0d v=%h",
                   write_posx, write_posy, write_value, mon_e[45:38], mon_e[37:32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic push_rows(input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = 0; x < 160; x++)
        exp_q.push_back({8'(x), 6'(y), CLR});
  endtask

  task automatic model_newline();
    if (m_row < 44) m_row++;
    else begin
      push_rows(m_voff, m_voff);
      m_voff = (m_voff == 44) ? 0 : m_voff + 1;
    end
  endtask

  task automatic model_reset();
    m_col = 0;
    m_row = 0;
    m_voff = 0;
    if (INIT_EN) push_rows(0, 44);
  endtask

  task automatic send(input logic [7:0] d, input logic [11:0] f, input logic [11:0] b);
    int t = 0;
    while (!char_ready && t < 10000) begin
      @(posedge clk); #1;
      t++;
    end
    stalls = t;
    if (!char_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got char_ready=0 expected 1 within 10000 cycles");
    end else begin
      char_valid = 1'b1;
      char_data = d;
      char_fg = f;
      char_bg = b;
      @(posedge clk); #1;
      char_valid = 1'b0;
      if (d == 8'h0D) m_col = 0;
      else if (d == 8'h08) begin
        if (m_col > 0) m_col--;
      end else if (d == 8'h0A) model_newline();
      else begin
        exp_q.push_back({8'(m_col), 6'((m_row + m_voff) % 45), f, b, d});
        if (m_col < 159) m_col++;
        else begin
          m_col = 0;
          model_newline();
        end
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (!char_ready && t < 10000) begin
      @(posedge clk); #1;
      t++;
    end
    chk(name, 32'(char_ready), 32'd1);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 10000) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b1;
    char_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    if (check) begin
      chk("rst_ready", 32'(char_ready), 32'(!INIT_EN));
      chk("rst_busy", 32'(busy), 32'(INIT_EN));
      chk("rst_we", 32'(write_enable), 32'd0);
      chk("rst_voff", 32'(v_offset), 32'd0);
      chk("rst_pos", {18'd0, write_posx, write_posy}, 32'd0);
      chk("rst_value", write_value, 32'd0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, max_st;
    logic [5:0] prev_v;
    // single glyph and reset values
    do_reset(1'b1);
    send(8'h41, 12'hFFF, 12'h000);
    chk("t1_we", 32'(write_enable), 32'd1);
    chk("t1_value", write_value, 32'hFFF00041);
    send(8'h42, 12'h123, 12'h456);
    drain("t1_drain");
    // 161 back-to-back glyphs, wrap to next row
    do_reset(1'b0);
    max_st = 0;
    for (int i = 0; i < 161; i++) begin
      send(8'h78, 12'hABC, 12'h012);
      if (i > 0 && stalls > max_st) max_st = stalls;
    end
    chk("t2_stalls", 32'(max_st), 32'd0);
    drain("t2_drain");
    // bottom-row LF scroll timing
    do_reset(1'b0);
    for (int i = 0; i < 44; i++) send(8'h0A, 12'h0, 12'h0);
    send(8'h0A, 12'h0, 12'h0);
    k = 1;
    chk("t3_ready_low", 32'(char_ready), 32'd0);
    chk("t3_we_first", 32'(write_enable), 32'd1);
    prev_v = v_offset;
    while (!char_ready && k < 400) begin
      prev_v = v_offset;
      @(posedge clk); #1;
      k++;
      if (k == 160) chk("t3_we_last", 32'(write_enable), 32'd1);
      if (k == 161) chk("t3_we_after", 32'(write_enable), 32'd0);
    end
    chk("t3_ready_cycle", 32'(k), 32'd162);
    chk("t3_voff_before", 32'(prev_v), 32'd0);
    chk("t3_voff_after", 32'(v_offset), 32'd1);
    drain("t3_drain");
    // glyph on bottom row after one scroll wraps physical row to 0
    send(8'h5A, 12'h00F, 12'hF00);
    drain("t4_glyph");
    // remaining 44 scrolls walk v_offset back to 0
    for (int i = 0; i < 44; i++) begin
      send(8'h0A, 12'h0, 12'h0);
      wait_ready("t4_ready");
      chk("t4_voff", 32'(v_offset), 32'(m_voff));
    end
    chk("t4_voff_wrap", 32'(v_offset), 32'd0);
    drain("t4_drain");
    // BS and CR editing
    do_reset(1'b0);
    send(8'h41, 12'h111, 12'h222);
    send(8'h42, 12'h111, 12'h222);
    send(8'h08, 12'h111, 12'h222);
    send(8'h43, 12'h333, 12'h444);
    send(8'h0D, 12'h111, 12'h222);
    send(8'h44, 12'h555, 12'h666);
    send(8'h0D, 12'h111, 12'h222);
    send(8'h08, 12'h111, 12'h222);
    send(8'h45, 12'h777, 12'h888);
    drain("t5_drain");
    // reset in the middle of a clear
    for (int i = 0; i < 44; i++) send(8'h0A, 12'h0, 12'h0);
    send(8'h0A, 12'h0, 12'h0);
    repeat (49) @(posedge clk);
    #1;
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("t6_we", 32'(write_enable), 32'd0);
    chk("t6_voff", 32'(v_offset), 32'd0);
    chk("t6_ready", 32'(char_ready), 32'(!INIT_EN));
    rst = 1'b0;
    model_reset();
    wait_ready("t6_ready_after");
    drain("t6_drain");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
